// File: rtl/platform_collision_pkg.sv
// Shared game constants for the platform collision block: screen and player
// geometry, FSM state encoding and the "no ground found" marker.
package platform_collision_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PLAYER_W = 16;
    localparam int PLAYER_H = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [9:0] GROUND_NONE = 10'h3FF;

    typedef struct packed {
        logic ground;
        logic ceiling;
        logic left;
        logic right;
    } coll_flags_t;

    // Half-open range test [lo, hi) on the widened 11-bit coordinates.
    function automatic logic in_range(input logic [10:0] v,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/platform_collision_probe.sv
// One sticky collision flag: set by a platform pixel inside its probe window,
// restarted at frame start (where the frame-start pixel itself still counts).
module collision_probe (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic in_window,
    input  logic platforms_on,
    output logic hit
);

    logic set_hit;

    assign set_hit = enable & in_window & platforms_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit <= 1'b0;
        end else if (clear) begin
            hit <= set_hit;
        end else if (set_hit) begin
            hit <= 1'b1;
        end
    end

endmodule

// File: rtl/platform_collision.sv
// Scans one video frame for platform pixels around the player box and reports
// ground / ceiling / wall contacts plus the nearest ground row once per frame.
module platform_collision #(
    parameter int PLAYER_W = platform_collision_pkg::PLAYER_W,
    parameter int PLAYER_H = platform_collision_pkg::PLAYER_H,
    parameter int H_ACTIVE = platform_collision_pkg::H_ACTIVE,
    parameter int V_ACTIVE = platform_collision_pkg::V_ACTIVE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       video_on,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       platforms_on,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       on_ground,
    output logic       hit_ceiling,
    output logic       block_left,
    output logic       block_right,
    output logic [9:0] ground_y,
    output logic       coll_valid
);

    import platform_collision_pkg::*;

    localparam logic [10:0] W11    = 11'(PLAYER_W);
    localparam logic [10:0] H11    = 11'(PLAYER_H);
    localparam logic [10:0] HA11   = 11'(H_ACTIVE);
    localparam logic [10:0] VA11   = 11'(V_ACTIVE);
    localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);

    logic [1:0]  state;
    logic [9:0]  lat_px;
    logic [9:0]  lat_py;
    logic        frame_start;
    logic        frame_end;
    logic        load;
    logic        counting;
    logic [10:0] px11;
    logic [10:0] py11;
    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] feet_row;
    logic [10:0] right_col;
    logic        in_active;
    logic        in_span;
    logic        in_rows;
    logic        gy_set;
    logic [9:0]  gy_acc;
    logic [9:0]  held_gy;
    coll_flags_t win;
    coll_flags_t acc;
    coll_flags_t held;

    assign frame_start = video_on && (x == 10'd0) && (y == 10'd0);
    assign frame_end   = video_on && (x == X_LAST) && (y == Y_LAST);
    assign load        = frame_start && (state != ST_REPORT);

    // The frame-start pixel is judged against the position being latched now.
    assign px11 = {1'b0, (load ? player_x : lat_px)};
    assign py11 = {1'b0, (load ? player_y : lat_py)};
    assign x11  = {1'b0, x};
    assign y11  = {1'b0, y};

    assign feet_row  = py11 + H11;
    assign right_col = px11 + W11;
    assign in_active = (x11 < HA11) && (y11 < VA11);
    assign counting  = (load || (state == ST_SCAN)) && video_on && in_active;
    assign in_span   = in_range(x11, px11, right_col);
    assign in_rows   = in_range(y11, py11, feet_row);

    always_comb begin
        win         = '0;
        win.ground  = (y11 == feet_row) && in_span;
        win.ceiling = (py11 != 11'd0) && (y11 == py11 - 11'd1) && in_span;
        win.left    = (px11 != 11'd0) && (x11 == px11 - 11'd1) && in_rows;
        win.right   = (x11 == right_col) && in_rows;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (frame_start) state <= ST_SCAN;
                ST_SCAN:   if (!frame_start && frame_end) state <= ST_REPORT;
                ST_REPORT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_px <= 10'd0;
            lat_py <= 10'd0;
        end else if (load) begin
            lat_px <= player_x;
            lat_py <= player_y;
        end
    end

    collision_probe u_ground (
        .clk(clk), .rst_n(rst_n), .clear(load), .enable(counting),
        .in_window(win.ground), .platforms_on(platforms_on), .hit(acc.ground)
    );

    collision_probe u_ceiling (
        .clk(clk), .rst_n(rst_n), .clear(load), .enable(counting),
        .in_window(win.ceiling), .platforms_on(platforms_on), .hit(acc.ceiling)
    );

    collision_probe u_left (
        .clk(clk), .rst_n(rst_n), .clear(load), .enable(counting),
        .in_window(win.left), .platforms_on(platforms_on), .hit(acc.left)
    );

    collision_probe u_right (
        .clk(clk), .rst_n(rst_n), .clear(load), .enable(counting),
        .in_window(win.right), .platforms_on(platforms_on), .hit(acc.right)
    );

    // Rows arrive in ascending order, so the first qualifying hit is the topmost.
    assign gy_set = counting && platforms_on && (y11 >= feet_row) && in_span;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gy_acc <= GROUND_NONE;
        end else if (load) begin
            gy_acc <= gy_set ? y : GROUND_NONE;
        end else if (gy_set && (gy_acc == GROUND_NONE)) begin
            gy_acc <= y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held    <= '0;
            held_gy <= GROUND_NONE;
        end else if (state == ST_REPORT) begin
            held    <= acc;
            held_gy <= gy_acc;
        end
    end

    // During REPORT the fresh results go straight out; afterwards the copy holds.
    assign coll_valid  = (state == ST_REPORT);
    assign on_ground   = coll_valid ? acc.ground  : held.ground;
    assign hit_ceiling = coll_valid ? acc.ceiling : held.ceiling;
    assign block_left  = coll_valid ? acc.left    : held.left;
    assign block_right = coll_valid ? acc.right   : held.right;
    assign ground_y    = coll_valid ? gy_acc      : held_gy;

endmodule

// File: tb/tb_platform_collision.sv
// Self-checking bench for platform_collision: directed frames from a table,
// reset and truncated-frame sequences, and random maps against a pixel model.
module tb_platform_collision;

    localparam int PW = 16;
    localparam int PH = 16;
    localparam int HA = 640;
    localparam int VA = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       platforms_on = 1'b0;
    logic [9:0] player_x = 10'd0;
    logic [9:0] player_y = 10'd0;
    logic       on_ground;
    logic       hit_ceiling;
    logic       block_left;
    logic       block_right;
    logic [9:0] ground_y;
    logic       coll_valid;

    always #5 clk = ~clk;

    platform_collision dut (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y),
        .platforms_on(platforms_on), .player_x(player_x), .player_y(player_y),
        .on_ground(on_ground), .hit_ceiling(hit_ceiling), .block_left(block_left),
        .block_right(block_right), .ground_y(ground_y), .coll_valid(coll_valid)
    );

    typedef struct {
        bit vo;
        int cx;
        int cy;
        bit pon;
    } pix_t;

    typedef struct {
        int px;
        int py;
        int alt_px;
        bit og;
        bit hc;
        bit bl;
        bit br;
        int gy;
    } vec_t;

    pix_t pix_q[$];
    vec_t vecs[6];
    int   rx0[4], rx1[4], ry0[4], ry1[4];
    int   nrect;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   full_frames = 0;

    always @(negedge clk) if (coll_valid === 1'b1) pulses++;

    // Side walls are always present; rectangles are inclusive bounds.
    function automatic bit is_plat(input int cx, input int cy);
        if (cx < 16 || cx >= HA - 16) return 1'b1;
        for (int i = 0; i < nrect; i++)
            if (cx >= rx0[i] && cx <= rx1[i] && cy >= ry0[i] && cy <= ry1[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model(input int px, input int py, output bit og, output bit hc,
                                  output bit bl, output bit br, output int gy);
        og = 0; hc = 0; bl = 0; br = 0; gy = 1023;
        foreach (pix_q[i]) begin
            int cx = pix_q[i].cx;
            int cy = pix_q[i].cy;
            bit span = (cx >= px) && (cx < px + PW);
            bit rows = (cy >= py) && (cy < py + PH);
            if (pix_q[i].vo && pix_q[i].pon && cx < HA && cy < VA) begin
                if (cy == py + PH && span) og = 1;
                if (py > 0 && cy == py - 1 && span) hc = 1;
                if (px > 0 && cx == px - 1 && rows) bl = 1;
                if (cx == px + PW && rows) br = 1;
                if (cy >= py + PH && span && cy < gy) gy = cy;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drivePix(input bit vo, input int cx, input int cy, input bit pon);
        @(negedge clk);
        video_on = vo;
        x = 10'(cx);
        y = 10'(cy);
        platforms_on = pon;
        pix_q.push_back('{vo, cx, cy, pon});
    endtask

    // Drives a sparse but order-preserving frame: dense window rows around the
    // box, probe columns below it, and blanked decoys that must be ignored.
    task automatic applyStimulus(input int px, input int py, input int alt, input bit do_start,
                                 input int first_row, input int end_row, input bit do_end);
        int r0;
        int cols[$];
        if (do_start) begin
            player_x = 10'(px);
            player_y = 10'(py);
            pix_q.delete();
            drivePix(1'b1, 0, 0, is_plat(0, 0));
            @(posedge clk);
            #1 player_x = 10'(alt);
        end
        r0 = (py - 2 > first_row) ? py - 2 : first_row;
        if (r0 < 0) r0 = 0;
        for (int r = r0; r < end_row && r < VA; r++) begin
            bit dense = (r <= py + PH + 1);
            cols.delete();
            if (dense) begin
                for (int c = px - 2; c <= px + PW + 1; c++) cols.push_back(c);
                cols.push_back(int'($urandom_range(0, HA - 1)));
            end else begin
                cols.push_back(px - 1);
                cols.push_back(px);
                cols.push_back(px + PW - 1);
                cols.push_back(px + PW);
            end
            if (alt != px) cols.push_back(alt + 1);
            foreach (cols[i]) begin
                int c = cols[i];
                if (c >= 0 && c < HA && !(c == 0 && r == 0) && !(c == HA - 1 && r == VA - 1))
                    drivePix(1'b1, c, r, is_plat(c, r));
            end
            if (dense) drivePix(1'b0, px, r, 1'b1);
        end
        if (do_end) drivePix(1'b1, HA - 1, VA - 1, is_plat(HA - 1, VA - 1));
    endtask

    task automatic checkFrame(input string tag, input bit og, input bit hc, input bit bl,
                              input bit br, input int gy);
        @(negedge clk);
        checkOutput($sformatf("%s coll_valid", tag), coll_valid, 1);
        checkOutput($sformatf("%s on_ground", tag), on_ground, og);
        checkOutput($sformatf("%s hit_ceiling", tag), hit_ceiling, hc);
        checkOutput($sformatf("%s block_left", tag), block_left, bl);
        checkOutput($sformatf("%s block_right", tag), block_right, br);
        checkOutput($sformatf("%s ground_y", tag), ground_y, gy);
        video_on = 1'b0;
        platforms_on = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("%s valid_one_cycle", tag), coll_valid, 0);
        checkOutput($sformatf("%s hold_ground_y", tag), ground_y, gy);
        checkOutput($sformatf("%s hold_on_ground", tag), on_ground, og);
        full_frames++;
        repeat (3) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput($sformatf("%s on_ground", tag), on_ground, 0);
        checkOutput($sformatf("%s hit_ceiling", tag), hit_ceiling, 0);
        checkOutput($sformatf("%s block_left", tag), block_left, 0);
        checkOutput($sformatf("%s block_right", tag), block_right, 0);
        checkOutput($sformatf("%s ground_y", tag), ground_y, 1023);
        checkOutput($sformatf("%s coll_valid", tag), coll_valid, 0);
    endtask

    initial begin
        int p0;
        int rpx, rpy, ralt, egy;
        bit eog, ehc, ebl, ebr;

        vecs[0] = '{32, 116, 32, 1, 0, 0, 0, 132};
        vecs[1] = '{32, 148, 32, 0, 1, 0, 0, 1023};
        vecs[2] = '{16, 60, 16, 0, 0, 1, 0, 132};
        vecs[3] = '{608, 60, 608, 0, 0, 0, 1, 1023};
        vecs[4] = '{0, 60, 0, 1, 1, 0, 0, 76};
        vecs[5] = '{300, 50, 40, 0, 0, 0, 0, 215};

        nrect = 2;
        rx0[0] = 16;  rx1[0] = 159; ry0[0] = 132; ry1[0] = 147;
        rx0[1] = 81;  rx1[1] = 560; ry0[1] = 215; ry1[1] = 230;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].px, vecs[i].py, vecs[i].alt_px, 1'b1, 0, VA, 1'b1);
            checkFrame($sformatf("vec%0d", i), vecs[i].og, vecs[i].hc, vecs[i].bl,
                       vecs[i].br, vecs[i].gy);
        end

        // Reset in the middle of a frame discards it; only the next full frame reports.
        p0 = pulses;
        applyStimulus(32, 116, 32, 1'b1, 0, 240, 1'b0);
        @(negedge clk);
        video_on = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("midreset");
        rst_n = 1'b1;
        applyStimulus(32, 116, 32, 1'b0, 240, VA, 1'b1);
        @(negedge clk);
        video_on = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midreset no_report", pulses - p0, 0);
        checkOutput("midreset ground_y_after", ground_y, 1023);
        applyStimulus(32, 116, 32, 1'b1, 0, VA, 1'b1);
        checkFrame("after_reset", 1, 0, 0, 0, 132);
        checkOutput("after_reset single_pulse", pulses - p0, 1);

        // A new frame start inside SCAN restarts with cleared accumulators.
        p0 = pulses;
        applyStimulus(32, 116, 32, 1'b1, 0, 141, 1'b0);
        applyStimulus(32, 148, 32, 1'b1, 0, VA, 1'b1);
        checkFrame("truncated", 0, 1, 0, 0, 1023);
        checkOutput("truncated single_pulse", pulses - p0, 1);

        for (int k = 0; k < 6; k++) begin
            nrect = 3;
            for (int j = 0; j < 3; j++) begin
                rx0[j] = int'($urandom_range(0, 600));
                rx1[j] = rx0[j] + int'($urandom_range(10, 200));
                ry0[j] = int'($urandom_range(0, 460));
                ry1[j] = ry0[j] + int'($urandom_range(3, 20));
            end
            rpx  = int'($urandom_range(0, 620));
            rpy  = int'($urandom_range(0, 470));
            ralt = ($urandom_range(0, 1) == 0) ? rpx : int'($urandom_range(0, 620));
            applyStimulus(rpx, rpy, ralt, 1'b1, 0, VA, 1'b1);
            model(rpx, rpy, eog, ehc, ebl, ebr, egy);
            checkFrame($sformatf("rand%0d(%0d,%0d)", k, rpx, rpy), eog, ehc, ebl, ebr, egy);
        end

        checkOutput("total_reports", pulses, full_frames);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/platform_collision.md
PLATFORM_COLLISION -- requirements
Module: platform_collision

Interface
REQ-001 Parameters: PLAYER_W, default 16, player box width in px; PLAYER_H, default 16, player box height in px; H_ACTIVE, default 640, active columns; V_ACTIVE, default 480, active rows.
REQ-002 Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- video_on  in  1  active-area flag.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- platforms_on  in  1  platform/wall layer pixel flag, aligned with the same-cycle x,y.
- player_x  in  10  player box left column.
- player_y  in  10  player box top row.
- on_ground  out  1  platform directly below the feet.
- hit_ceiling  out  1  platform directly above the head.
- block_left  out  1  platform directly left of the box.
- block_right  out  1  platform directly right of the box.
- ground_y  out  10  topmost platform row at or below the feet within the box column span; 10'h3FF if none.
- coll_valid  out  1  one-cycle pulse when the outputs update.
REQ-003 The block has one clock and one reset; reset is asynchronous and active-low.

Function
REQ-004 States: IDLE, SCAN, REPORT.
- IDLE -> SCAN on a cycle with video_on=1, x=0, y=0.
- SCAN -> REPORT on a cycle with video_on=1, x=H_ACTIVE-1, y=V_ACTIVE-1.
- REPORT -> IDLE unconditionally after 1 cycle.
REQ-005 On the IDLE->SCAN cycle, player_x/player_y are latched for the whole frame. Accumulators clear to 0, except ground_y, which clears to 3FF. That cycle's pixel is evaluated against the newly latched position.
REQ-006 Probe geometry uses 11-bit unsigned arithmetic. Sums never wrap:
- feet row F = py+PLAYER_H.
- head row = py-1; disabled when py=0.
- left column = px-1; disabled when px=0.
- right column R = px+PLAYER_W.
- span = px..px+PLAYER_W-1.
REQ-007 In SCAN, a pixel counts only when video_on=1 and platforms_on=1.
REQ-008 Ground probe: y=F and x in span sets the ground accumulator.
REQ-009 Ceiling probe: y=py-1 and x in span sets the ceiling accumulator.
REQ-010 Left probe: x=px-1 and y in py..F-1 sets the left accumulator.
REQ-011 Right probe: x=R and y in py..F-1 sets the right accumulator.
REQ-012 The ground_y accumulator takes y on the first counted pixel with y>=F and x in span. Later hits do not change it, because rows are scanned in ascending order.
REQ-013 Probes lying outside the active area never hit; no error is flagged.
REQ-014 In REPORT, all accumulators are copied to the outputs and coll_valid=1 for exactly that cycle. Outputs hold until the next REPORT.
REQ-015 Latency: outputs reflect the frame ending at (H_ACTIVE-1, V_ACTIVE-1) and are valid 1 cycle after that pixel.
REQ-016 player_x/player_y changes during SCAN have no effect until the next frame start.
REQ-017 A frame-start pixel seen while in SCAN (truncated frame) restarts SCAN with cleared accumulators. No REPORT occurs for the truncated frame.

Reset
REQ-018 While rst_n=0: state=IDLE; on_ground, hit_ceiling, block_left, block_right, coll_valid=0; ground_y=3FF; accumulators and latched position cleared.
REQ-019 Reset asserted mid-SCAN discards the frame. After release, the block waits in IDLE for the next frame start and emits no coll_valid for the partial frame.

Structure
REQ-020 The shared game constants package holds:
- H_ACTIVE, V_ACTIVE, PLAYER_W, PLAYER_H.
- the state encoding localparams.
- the GROUND_NONE=10'h3FF constant.
REQ-021 Sub-module collision_probe: a registered flag set by (enable & in-window & platforms_on) and cleared on frame start. It is instantiated 4 times (ground, ceiling, left, right); ground_y logic stays in the top.

Verification
REQ-022 The bench drives a 640x480 scan. Platforms occupy rows 132..147 at cols 16..159, rows 215..230 at cols 81..560, and cols 0..15 and 624..639 in all rows.
REQ-023 Player (32,116) -> next coll_valid: on_ground=1, ground_y=132, hit_ceiling=0, block_left=0, block_right=0.
REQ-024 Player (32,148) -> hit_ceiling=1, on_ground=0, ground_y=3FF.
REQ-025 Player (16,60) -> block_left=1. Player (608,60) -> block_right=1. Player (0,60) -> block_left=0, with no wrap false hit at x=1023.
REQ-026 Player (300,50) -> all flags 0, ground_y=215. player_x changed to 40 mid-frame -> this frame's report is still computed from x=300.
REQ-027 rst_n pulsed low at y=240 of a frame -> outputs reset values, no coll_valid that frame. coll_valid=1 exactly once, after the next complete frame.
